// File: rtl/spawn_coord_generator.sv
// -----------------------------------------------------------------------------
// spawn_coord_generator
//
// Purpose: draws a spawn lane from a free-running Galois LFSR using unbiased
// rejection sampling, additionally rejecting any lane found in a short
// history of recent picks. After MAX_TRY rejected draws a deterministic
// fallback (lowest lane not in history) is taken. The chosen lane plus the
// requested edge direction are mapped to a packed {x,y} playfield coordinate.
//
// Ports:
//   spawn_clock   in   system clock
//   spawn_reset   in   asynchronous active-high reset
//   seed_load     in   load seed_value into the LFSR this edge (0 loads 1)
//   seed_value    in   [LFSR_W]   seed to load
//   req           in   request one coordinate (sampled only while idle)
//   dir           in   [2]        edge: 0 top, 1 right, 2 bottom, 3 left
//   busy          out  high while a draw is in progress
//   valid         out  one-cycle pulse: lane_out/coord updated
//   fallback      out  high with valid when the fallback chose the lane
//   lane_out      out  [SEL_W]   chosen lane, held until next valid
//   coord         out  [X_W+Y_W] {x,y}, held until next valid
//   rand_state    out  [LFSR_W]  current LFSR value
// -----------------------------------------------------------------------------
module spawn_coord_generator #(
  parameter int                LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] TAPS        = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED        = 16'h0001,
  parameter int                LANES       = 5,
  parameter int                HIST_DEPTH  = 1,
  parameter int                MAX_TRY     = 8,
  parameter int                X_W         = 8,
  parameter int                Y_W         = 7,
  parameter int                COORD_BASE  = 7,
  parameter int                COORD_PITCH = 21,
  parameter int                EDGE_MIN    = 7,
  parameter int                EDGE_MAX    = 111,
  localparam int               SEL_W       = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int               TRY_W       = (MAX_TRY > 1) ? $clog2(MAX_TRY + 1) : 1
) (
  input  logic                 spawn_clock,
  input  logic                 spawn_reset,
  input  logic                 seed_load,
  input  logic [LFSR_W-1:0]    seed_value,
  input  logic                 req,
  input  logic [1:0]           dir,
  output logic                 busy,
  output logic                 valid,
  output logic                 fallback,
  output logic [SEL_W-1:0]     lane_out,
  output logic [X_W+Y_W-1:0]   coord,
  output logic [LFSR_W-1:0]    rand_state
);

  localparam logic [LFSR_W-1:0] LFSR_ONE   = {{(LFSR_W-1){1'b0}}, 1'b1};
  // The all-zero state would lock the LFSR, so it is never loaded.
  localparam logic [LFSR_W-1:0] SEED_INIT  = (SEED == '0) ? LFSR_ONE : SEED;
  localparam logic [SEL_W:0]    LANE_LIMIT = (SEL_W + 1)'(LANES);
  localparam logic [TRY_W-1:0]  TRY_LAST   = TRY_W'(MAX_TRY - 1);
  localparam logic [X_W-1:0]    X_MIN      = X_W'(EDGE_MIN);
  localparam logic [X_W-1:0]    X_MAX      = X_W'(EDGE_MAX);
  localparam logic [Y_W-1:0]    Y_MIN      = Y_W'(EDGE_MIN);
  localparam logic [Y_W-1:0]    Y_MAX      = Y_W'(EDGE_MAX);
  localparam logic [X_W-1:0]    X_BASE     = X_W'(COORD_BASE);
  localparam logic [X_W-1:0]    X_PITCH    = X_W'(COORD_PITCH);
  localparam logic [Y_W-1:0]    Y_BASE     = Y_W'(COORD_BASE);
  localparam logic [Y_W-1:0]    Y_PITCH    = Y_W'(COORD_PITCH);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t                state_reg, state_next;
  logic [LFSR_W-1:0]     lfsr_reg, lfsr_next;
  logic [1:0]            dir_reg, dir_next;
  logic [TRY_W-1:0]      try_reg, try_next;
  logic                  valid_reg, fallback_reg;
  logic [SEL_W-1:0]      lane_reg;
  logic [X_W+Y_W-1:0]    coord_reg;
  logic [SEL_W-1:0]      hist_lane_reg [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hist_vld_reg;

  logic [SEL_W-1:0]      cand;
  logic [HIST_DEPTH-1:0] hist_hit;
  logic                  cand_ok;
  logic [LANES-1:0][HIST_DEPTH-1:0] lane_match;
  logic [LANES-1:0]      lane_used;
  logic [SEL_W-1:0]      fb_lane;
  logic                  take, take_fb;
  logic [SEL_W-1:0]      sel_lane;
  logic [X_W-1:0]        pos_x, x_val;
  logic [Y_W-1:0]        pos_y, y_val;

  // LFSR: seed_load wins over the free-running step.
  always_comb begin
    lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ TAPS) : (lfsr_reg >> 1);
    if (seed_load) begin
      lfsr_next = (seed_value == '0) ? LFSR_ONE : seed_value;
    end
  end

  assign cand = lfsr_reg[SEL_W-1:0];

  // Candidate hits any valid history entry.
  genvar gi, gj;
  generate
    for (gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist_hit
      assign hist_hit[gi] = hist_vld_reg[gi] && (hist_lane_reg[gi] == cand);
    end
  endgenerate

  assign cand_ok = ({1'b0, cand} < LANE_LIMIT) && (hist_hit == '0);

  // Per-lane "present in history" flags feed the fallback priority pick.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane_used
      for (gj = 0; gj < HIST_DEPTH; gj++) begin : g_entry
        assign lane_match[gi][gj] = hist_vld_reg[gj] &&
                                    (hist_lane_reg[gj] == SEL_W'(gi));
      end
      assign lane_used[gi] = |lane_match[gi];
    end
  endgenerate

  // Lowest-index free lane; HIST_DEPTH < LANES guarantees one exists.
  always_comb begin
    fb_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (!lane_used[i]) fb_lane = SEL_W'(i);
    end
  end

  // FSM next state and draw decision.
  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    try_next   = try_reg;
    take       = 1'b0;
    take_fb    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          dir_next   = dir;
          try_next   = '0;
          state_next = DRAW;
        end
      end
      DRAW: begin
        if (cand_ok) begin
          take       = 1'b1;
          state_next = IDLE;
        end else if (try_reg == TRY_LAST) begin
          // This rejection is the MAX_TRY-th one: resolve in the same edge.
          take       = 1'b1;
          take_fb    = 1'b1;
          state_next = IDLE;
        end else begin
          try_next   = try_reg + TRY_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sel_lane = take_fb ? fb_lane : cand;

  // Position along the edge, computed modulo each field width.
  assign pos_x = X_BASE + X_W'(sel_lane) * X_PITCH;
  assign pos_y = Y_BASE + Y_W'(sel_lane) * Y_PITCH;

  always_comb begin
    x_val = X_MIN;
    y_val = pos_y;
    case (dir_reg)
      2'd0: begin x_val = pos_x; y_val = Y_MIN; end
      2'd1: begin x_val = X_MAX; y_val = pos_y; end
      2'd2: begin x_val = pos_x; y_val = Y_MAX; end
      default: begin x_val = X_MIN; y_val = pos_y; end
    endcase
  end

  always_ff @(posedge spawn_clock or posedge spawn_reset) begin
    if (spawn_reset) begin
      lfsr_reg     <= SEED_INIT;
      state_reg    <= IDLE;
      dir_reg      <= '0;
      try_reg      <= '0;
      valid_reg    <= 1'b0;
      fallback_reg <= 1'b0;
      lane_reg     <= '0;
      coord_reg    <= '0;
      hist_vld_reg <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_lane_reg[i] <= '0;
    end else begin
      lfsr_reg     <= lfsr_next;
      state_reg    <= state_next;
      dir_reg      <= dir_next;
      try_reg      <= try_next;
      valid_reg    <= take;
      fallback_reg <= take_fb;
      if (take) begin
        lane_reg  <= sel_lane;
        coord_reg <= {x_val, y_val};
        // Newest pick enters at index 0; the oldest falls off the end.
        for (int i = HIST_DEPTH - 1; i > 0; i--) begin
          hist_lane_reg[i] <= hist_lane_reg[i-1];
          hist_vld_reg[i]  <= hist_vld_reg[i-1];
        end
        hist_lane_reg[0] <= sel_lane;
        hist_vld_reg[0]  <= 1'b1;
      end
    end
  end

  assign busy       = (state_reg != IDLE);
  assign valid      = valid_reg;
  assign fallback   = fallback_reg;
  assign lane_out   = lane_reg;
  assign coord      = coord_reg;
  assign rand_state = lfsr_reg;

endmodule

// File: tb/tb_spawn_coord_generator.sv
// -----------------------------------------------------------------------------
// tb_spawn_coord_generator
//
// Bench for spawn_coord_generator. u0 uses default parameters, u1 uses
// LANES=2 / HIST_DEPTH=1 / MAX_TRY=1. Requests are issued together with a
// seed_load so that the LFSR samples, and hence the lanes, are known in
// advance. Expected responses go into per-instance queues; a monitor per
// instance pops and compares whenever valid is seen.
// -----------------------------------------------------------------------------
module tb_spawn_coord_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        seed_load0 = 1'b0, req0 = 1'b0;
  logic [15:0] seed_value0 = '0;
  logic [1:0]  dir0 = '0;
  logic        busy0, valid0, fb0;
  logic [2:0]  lane0;
  logic [14:0] coord0;
  logic [15:0] rs0;

  logic        seed_load1 = 1'b0, req1 = 1'b0;
  logic [15:0] seed_value1 = '0;
  logic [1:0]  dir1 = '0;
  logic        busy1, valid1, fb1;
  logic [0:0]  lane1;
  logic [14:0] coord1;
  logic [15:0] rs1;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;
  longint last_v0 = -1;
  longint last_v1 = -1;

  typedef struct {
    int     lane;
    int     coord;
    bit     fb;
    bit     fb_chk;
    longint cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  spawn_coord_generator u0 (
    .spawn_clock (clk),
    .spawn_reset (rst),
    .seed_load   (seed_load0),
    .seed_value  (seed_value0),
    .req         (req0),
    .dir         (dir0),
    .busy        (busy0),
    .valid       (valid0),
    .fallback    (fb0),
    .lane_out    (lane0),
    .coord       (coord0),
    .rand_state  (rs0)
  );

  spawn_coord_generator #(.LANES(2), .HIST_DEPTH(1), .MAX_TRY(1)) u1 (
    .spawn_clock (clk),
    .spawn_reset (rst),
    .seed_load   (seed_load1),
    .seed_value  (seed_value1),
    .req         (req1),
    .dir         (dir1),
    .busy        (busy1),
    .valid       (valid1),
    .fallback    (fb1),
    .lane_out    (lane1),
    .coord       (coord1),
    .rand_state  (rs1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int pack_xy(input int x, input int y);
    return (x << 7) | y;
  endfunction

  // Coordinate for u1 lanes from the edge mapping.
  function automatic int xy_of(input int d, input int lane);
    int p;
    p = 7 + 21 * lane;
    case (d)
      0: return pack_xy(p, 7);
      1: return pack_xy(111, p);
      2: return pack_xy(p, 111);
      default: return pack_xy(7, p);
    endcase
  endfunction

  // ---------------- monitors ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid0) begin
        check("u0_busy_low_in_valid", busy0, 0);
        if (last_v0 >= 0) check("u0_valid_spacing_ge2", (cyc - last_v0) >= 2, 1);
        last_v0 = cyc;
        if (q0.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL u0_unexpected_valid: got lane=%0d coord=0x%0h at cycle %0d, expected no valid",
                   lane0, coord0, cyc);
        end else begin
          e = q0.pop_front();
          $display("[TB] u0 valid cyc=%0d lane=%0d coord=0x%0h fb=%0d", cyc, lane0, coord0, fb0);
          check("u0_lane", lane0, e.lane);
          check("u0_coord", coord0, e.coord);
          if (e.fb_chk) check("u0_fallback", fb0, e.fb);
          check("u0_valid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid1) begin
        check("u1_busy_low_in_valid", busy1, 0);
        if (last_v1 >= 0) check("u1_valid_spacing_ge2", (cyc - last_v1) >= 2, 1);
        last_v1 = cyc;
        if (q1.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL u1_unexpected_valid: got lane=%0d coord=0x%0h at cycle %0d, expected no valid",
                   lane1, coord1, cyc);
        end else begin
          e = q1.pop_front();
          $display("[TB] u1 valid cyc=%0d lane=%0d coord=0x%0h fb=%0d", cyc, lane1, coord1, fb1);
          check("u1_lane", lane1, e.lane);
          check("u1_coord", coord1, e.coord);
          if (e.fb_chk) check("u1_fallback", fb1, e.fb);
          check("u1_valid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // ---------------- drivers (all run at posedge + #1) ----------------
  task automatic wait_idle0();
    int n = 0;
    while (busy0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("u0_idle_wait", busy0, 0);
  endtask

  task automatic wait_idle1();
    int n = 0;
    while (busy1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("u1_idle_wait", busy1, 0);
  endtask

  task automatic issue0(input logic [15:0] sd, input logic [1:0] d, input int lane,
                        input int x, input int y, input bit fb, input int draws);
    exp_t e;
    wait_idle0();
    e.lane = lane; e.coord = pack_xy(x, y); e.fb = fb; e.fb_chk = 1'b1;
    e.cyc = cyc + 1 + draws;
    q0.push_back(e);
    req0 = 1'b1; seed_load0 = 1'b1; seed_value0 = sd; dir0 = d;
    @(posedge clk); #1;
    req0 = 1'b0; seed_load0 = 1'b0; dir0 = ~d;
  endtask

  task automatic issue1(input logic [15:0] sd, input bit use_seed, input logic [1:0] d,
                        input int lane, input int crd, input bit fb, input bit fb_chk);
    exp_t e;
    wait_idle1();
    e.lane = lane; e.coord = crd; e.fb = fb; e.fb_chk = fb_chk;
    e.cyc = cyc + 2;
    q1.push_back(e);
    req1 = 1'b1; seed_load1 = use_seed; seed_value1 = sd; dir1 = d;
    @(posedge clk); #1;
    req1 = 1'b0; seed_load1 = 1'b0; dir1 = ~d;
  endtask

  // Held-request vectors.
  logic [15:0] h_seed [3] = '{16'h0007, 16'h0002, 16'h0002};
  logic [1:0]  h_dir  [3] = '{2'd1, 2'd2, 2'd0};
  int          h_lane [3] = '{3, 2, 1};
  int          h_x    [3] = '{111, 49, 28};
  int          h_y    [3] = '{70, 111, 7};
  int          h_draw [3] = '{2, 1, 2};

  initial begin
    int   n;
    int   hi;
    int   guard;
    int   alt;
    exp_t e;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("u0_rst_busy", busy0, 0);
    check("u0_rst_valid", valid0, 0);
    check("u0_rst_fallback", fb0, 0);
    check("u0_rst_lane", lane0, 0);
    check("u0_rst_coord", coord0, 0);
    check("u0_rst_rand", rs0, 16'h0001);
    check("u1_rst_lane", lane1, 0);
    check("u1_rst_coord", coord1, 0);
    @(negedge clk);
    rst = 1'b0;

    // LFSR stepping from SEED
    @(posedge clk); #1;
    check("lfsr_step1", rs0, 16'hB400);
    @(posedge clk); #1;
    check("lfsr_step2", rs0, 16'h5A00);
    seed_load0 = 1'b1; seed_value0 = 16'h0000;
    @(posedge clk); #1;
    seed_load0 = 1'b0;
    check("lfsr_seed_zero", rs0, 16'h0001);

    // Full period from 0x0001
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (rs0 != 16'h0001 && n < 70000);
    check("lfsr_period", n, 65535);

    // Directed draws on u0 (history after each noted in the vector order)
    issue0(16'h0003, 2'd0, 3,   70,   7, 1'b0, 1); // direct accept
    issue0(16'h0001, 2'd1, 1,  111,  28, 1'b0, 1); // accept, differs from 3
    issue0(16'h0001, 2'd2, 0,    7, 111, 1'b0, 2); // 1 repeats -> next sample 0
    issue0(16'h0007, 2'd3, 3,    7,  70, 1'b0, 2); // 7 out of range -> 3
    issue0(16'h03FF, 2'd0, 0,    7,   7, 1'b1, 8); // 8 rejects -> fallback 0
    issue0(16'h0004, 2'd1, 4,  111,  91, 1'b0, 1); // top lane
    issue0(16'h03FF, 2'd2, 0,    7, 111, 1'b1, 8); // fallback 0 (history 4)
    issue0(16'h03FF, 2'd3, 1,    7,  28, 1'b1, 8); // fallback skips lane 0

    // req held high; dir wiggled during DRAW must not matter
    wait_idle0();
    req0 = 1'b1;
    hi = 0;
    guard = 0;
    while (hi < 3 && guard < 40) begin
      if (!busy0) begin
        e.lane = h_lane[hi]; e.coord = pack_xy(h_x[hi], h_y[hi]);
        e.fb = 1'b0; e.fb_chk = 1'b1; e.cyc = cyc + 1 + h_draw[hi];
        q0.push_back(e);
        seed_load0 = 1'b1; seed_value0 = h_seed[hi]; dir0 = h_dir[hi];
        hi++;
      end else begin
        seed_load0 = 1'b0;
        dir0 = dir0 + 2'd1;
      end
      @(posedge clk); #1;
      guard++;
    end
    req0 = 1'b0; seed_load0 = 1'b0;
    check("held_req_issued", hi, 3);

    // u1: two lanes, one-entry history, single try
    issue1(16'h0002, 1'b1, 2'd0, 0, pack_xy(7, 7),    1'b0, 1'b1);
    issue1(16'h0002, 1'b1, 2'd0, 1, pack_xy(28, 7),   1'b1, 1'b1);
    issue1(16'h0000, 1'b1, 2'd1, 0, pack_xy(111, 7),  1'b1, 1'b1);
    issue1(16'h0001, 1'b1, 2'd3, 1, pack_xy(7, 28),   1'b0, 1'b1);
    issue1(16'h0010, 1'b1, 2'd2, 0, pack_xy(7, 111),  1'b0, 1'b1);
    issue1(16'hFFFF, 1'b1, 2'd1, 1, pack_xy(111, 28), 1'b0, 1'b1);
    // Free-running LFSR: lanes must still alternate
    alt = 0;
    for (int i = 0; i < 20; i++) begin
      issue1(16'h0000, 1'b0, 2'(i % 4), alt, xy_of(i % 4, alt), 1'b0, 1'b0);
      alt = 1 - alt;
    end
    wait_idle1();

    // Reset during a long draw
    wait_idle0();
    req0 = 1'b1; seed_load0 = 1'b1; seed_value0 = 16'h03FF; dir0 = 2'd0;
    @(posedge clk); #1;
    req0 = 1'b0; seed_load0 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("u0_busy_before_abort", busy0, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy0, 0);
    check("abort_valid", valid0, 0);
    check("abort_lane", lane0, 0);
    check("abort_coord", coord0, 0);
    check("abort_fallback", fb0, 0);
    check("abort_rand", rs0, 16'h0001);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_no_busy", busy0, 0);

    // Lane 1 was the last pre-reset pick; history must be empty now.
    issue0(16'h0001, 2'd1, 1, 111, 28, 1'b0, 1);
    wait_idle0();
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("u0_queue_drained", q0.size(), 0);
    check("u1_queue_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
